partoserial_multi: RTL and testbench

PARTOSERIAL_MULTI -- requirements
Module: partoserial_multi

---
 rtl/partoserial_multi.sv | 89 ++++++++
 tb/tb_partoserial_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/partoserial_multi.sv
// partoserial_multi: multi-lane parallel-to-serial converter.
// One shared bit counter on the bit-rate clock sets the word boundary for
// every lane. Each lane loads a word, an IDLE symbol or zeros at that
// boundary and then shifts the word out one bit per cycle.
module partoserial_multi #(
    parameter int               WIDTH     = 8,
    parameter int               LANES     = 1,
    parameter logic [WIDTH-1:0] IDLE      = WIDTH'(8'hBC),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                   clk_8f,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES-1:0]       lane_en,
    output logic                   load_out,
    output logic [LANES-1:0]       data_out,
    output logic [LANES-1:0]       active_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] bit_cnt;

    // Shared bit counter: 0..WIDTH-1 then wrap. Reset parks it on the last
    // position so the first edge after reset release is a load edge.
    always_ff @(posedge clk_8f) begin
        // NOTE: sequential state is updated with <= so every register
        // samples the values from before the edge, independent of order.
        if (reset) begin
            bit_cnt <= CNT_LAST;
        end else if (load_out) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    // The word boundary is the cycle in which the counter sits on its last
    // position; the closing edge of that cycle loads every lane.
    assign load_out = (bit_cnt == CNT_LAST);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] shreg;
        logic [WIDTH-1:0] shifted;
        logic             active;
        logic [WIDTH-1:0] word;

        assign word = data_in[l*WIDTH +: WIDTH];

        // Output end and shift direction follow the bit order; the vacated
        // end fills with 0 so a disabled lane stays quiet.
        if (MSB_FIRST) begin : g_msb
            assign shifted     = {shreg[WIDTH-2:0], 1'b0};
            assign data_out[l] = shreg[WIDTH-1];
        end else begin : g_lsb
            assign shifted     = {1'b0, shreg[WIDTH-1:1]};
            assign data_out[l] = shreg[0];
        end

        assign active_out[l] = active;

        // Lane shift register: load at the word boundary, shift otherwise.
        // Reset clears the register so the output is 0 and any partially
        // sent word is dropped.
        always_ff @(posedge clk_8f) begin
            if (reset) begin
                shreg  <= '0;
                active <= 1'b0;
            end else if (load_out) begin
                if (!lane_en[l]) begin
                    shreg  <= '0;
                    active <= 1'b0;
                end else if (valid_in[l]) begin
                    shreg  <= word;
                    active <= 1'b1;
                end else begin
                    shreg  <= IDLE;
                    active <= 1'b0;
                end
            end else begin
                shreg <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_partoserial_multi.sv
// Directed bench for partoserial_multi: three configurations (8-bit x2 lanes
// MSB first, 8-bit LSB first, 10-bit with a custom IDLE) driven by
// word-level tasks with hand-computed expected words.
module tb_partoserial_multi;

    logic clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    int tests = 0;
    int fails = 0;

    // Configuration A: WIDTH=8, LANES=2, MSB first, IDLE=BC
    logic        a_reset = 1'b1;
    logic [15:0] a_data  = '0;
    logic [1:0]  a_valid = '0;
    logic [1:0]  a_en    = '0;
    logic        a_load;
    logic [1:0]  a_dout;
    logic [1:0]  a_act;

    partoserial_multi #(.WIDTH(8), .LANES(2), .IDLE(8'hBC), .MSB_FIRST(1'b1)) dut_a (
        .clk_8f(clk_8f), .reset(a_reset), .data_in(a_data), .valid_in(a_valid),
        .lane_en(a_en), .load_out(a_load), .data_out(a_dout), .active_out(a_act)
    );

    // Configuration B: WIDTH=8, LANES=1, LSB first
    logic       b_reset = 1'b1;
    logic [7:0] b_data  = '0;
    logic       b_valid = 1'b0;
    logic       b_en    = 1'b0;
    logic       b_load;
    logic       b_dout;
    logic       b_act;

    partoserial_multi #(.WIDTH(8), .LANES(1), .IDLE(8'hBC), .MSB_FIRST(1'b0)) dut_b (
        .clk_8f(clk_8f), .reset(b_reset), .data_in(b_data), .valid_in(b_valid),
        .lane_en(b_en), .load_out(b_load), .data_out(b_dout), .active_out(b_act)
    );

    // Configuration C: WIDTH=10, LANES=1, MSB first, IDLE=17C
    logic       c_reset = 1'b1;
    logic [9:0] c_data  = '0;
    logic       c_valid = 1'b0;
    logic       c_en    = 1'b0;
    logic       c_load;
    logic       c_dout;
    logic       c_act;

    partoserial_multi #(.WIDTH(10), .LANES(1), .IDLE(10'h17C), .MSB_FIRST(1'b1)) dut_c (
        .clk_8f(clk_8f), .reset(c_reset), .data_in(c_data), .valid_in(c_valid),
        .lane_en(c_en), .load_out(c_load), .data_out(c_dout), .active_out(c_act)
    );

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk_8f);
        #1;
    endtask

    // One word period on A. Must be entered in a boundary cycle. Inputs are
    // applied before the load edge, then replaced by the mid-word values
    // (which must not affect this word). Bits are rebuilt MSB first.
    task automatic a_word(input logic [1:0] en, input logic [1:0] valid, input logic [15:0] data,
                          input logic [1:0] mid_en, input logic [1:0] mid_valid,
                          input logic [15:0] mid_data,
                          output logic [7:0] w0, output logic [7:0] w1,
                          output logic act0_all, output logic act0_any, output logic act1_any);
        logic load_quiet;
        tests++;
        if (a_load !== 1'b1) begin
            fails++;
            $display("FAIL a_boundary_load: got %b expected 1", a_load);
        end
        a_en = en; a_valid = valid; a_data = data;
        w0 = '0; w1 = '0;
        act0_all = 1'b1; act0_any = 1'b0; act1_any = 1'b0; load_quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                a_en = mid_en; a_valid = mid_valid; a_data = mid_data;
            end
            w0[7-i] = a_dout[0];
            w1[7-i] = a_dout[1];
            act0_all = act0_all & a_act[0];
            act0_any = act0_any | a_act[0];
            act1_any = act1_any | a_act[1];
            if (i < 7 && a_load !== 1'b0) load_quiet = 1'b0;
        end
        tests++;
        if (load_quiet !== 1'b1) begin
            fails++;
            $display("FAIL a_load_midword: got load_out high inside a word, expected low");
        end
    endtask

    // One word period on B, rebuilt LSB first (first serial bit is w[0]).
    task automatic b_word(input logic en, input logic valid, input logic [7:0] data,
                          output logic [7:0] w, output logic act_all, output logic act_any);
        b_en = en; b_valid = valid; b_data = data;
        w = '0; act_all = 1'b1; act_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin b_valid = 1'b0; b_data = ~data; end
            w[i] = b_dout;
            act_all = act_all & b_act;
            act_any = act_any | b_act;
        end
    endtask

    // One word period on C, rebuilt MSB first.
    task automatic c_word(input logic valid, input logic [9:0] data,
                          output logic [9:0] w, output logic act_all, output logic act_any);
        c_en = 1'b1; c_valid = valid; c_data = data;
        w = '0; act_all = 1'b1; act_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) c_valid = 1'b0;
            w[9-i] = c_dout;
            act_all = act_all & c_act;
            act_any = act_any | c_act;
        end
    endtask

    task automatic test_reset();
        a_reset = 1'b1; a_en = 2'b11; a_valid = 2'b11; a_data = 16'hFFFF;
        tick(); tick();
        tests++;
        if (a_dout !== 2'b00) begin fails++; $display("FAIL reset_dout: got %b expected 00", a_dout); end
        tests++;
        if (a_load !== 1'b1) begin fails++; $display("FAIL reset_load: got %b expected 1", a_load); end
        tests++;
        if (a_act !== 2'b00) begin fails++; $display("FAIL reset_active: got %b expected 00", a_act); end
        a_reset = 1'b0;
    endtask

    // Lane 0 enabled with no valid data sends BC back-to-back; lane 1 off.
    task automatic test_idle();
        logic [7:0] w0, w1;
        logic aa, ao, a1;
        for (int k = 0; k < 3; k++) begin
            a_word(2'b01, 2'b00, 16'h0000, 2'b01, 2'b00, 16'h0000, w0, w1, aa, ao, a1);
            tests++;
            if (w0 !== 8'hBC) begin fails++; $display("FAIL idle_lane0 word%0d: got %h expected bc", k, w0); end
            tests++;
            if (w1 !== 8'h00) begin fails++; $display("FAIL idle_lane1_off word%0d: got %h expected 00", k, w1); end
            tests++;
            if (ao !== 1'b0) begin fails++; $display("FAIL idle_active word%0d: got %b expected 0", k, ao); end
        end
    endtask

    // A5 valid for one word (mid-word input changes ignored), then BC.
    task automatic test_valid_word();
        logic [7:0] w0, w1;
        logic aa, ao, a1;
        a_word(2'b01, 2'b01, 16'h00A5, 2'b01, 2'b00, 16'h005A, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'hA5) begin fails++; $display("FAIL valid_a5: got %h expected a5", w0); end
        tests++;
        if (aa !== 1'b1) begin fails++; $display("FAIL valid_active_all: got %b expected 1", aa); end
        a_word(2'b01, 2'b00, 16'h00A5, 2'b01, 2'b00, 16'h00A5, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'hBC) begin fails++; $display("FAIL after_valid_idle: got %h expected bc", w0); end
        tests++;
        if (ao !== 1'b0) begin fails++; $display("FAIL after_valid_active: got %b expected 0", ao); end
    endtask

    task automatic test_lane_en();
        logic [7:0] w0, w1;
        logic aa, ao, a1;
        // lane_en[1] raised mid-word: lane 1 stays 0 until the next boundary
        a_word(2'b01, 2'b01, 16'h00F0, 2'b11, 2'b01, 16'h00F0, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'hF0) begin fails++; $display("FAIL lane_en_l0_f0: got %h expected f0", w0); end
        tests++;
        if (w1 !== 8'h00) begin fails++; $display("FAIL lane_en_l1_quiet: got %h expected 00", w1); end
        tests++;
        if (a1 !== 1'b0) begin fails++; $display("FAIL lane_en_l1_active: got %b expected 0", a1); end
        a_word(2'b11, 2'b00, 16'h0000, 2'b11, 2'b00, 16'h0000, w0, w1, aa, ao, a1);
        tests++;
        if (w1 !== 8'hBC) begin fails++; $display("FAIL lane_en_l1_bc: got %h expected bc", w1); end
        tests++;
        if (w0 !== 8'hBC) begin fails++; $display("FAIL lane_en_l0_bc: got %h expected bc", w0); end
        // lane_en dropped mid-word: the word in flight still completes
        a_word(2'b11, 2'b10, 16'h3C00, 2'b00, 2'b00, 16'h0000, w0, w1, aa, ao, a1);
        tests++;
        if (w1 !== 8'h3C) begin fails++; $display("FAIL lane_en_drop_l1: got %h expected 3c", w1); end
        tests++;
        if (a1 !== 1'b1) begin fails++; $display("FAIL lane_en_drop_active: got %b expected 1", a1); end
        a_word(2'b00, 2'b11, 16'hFFFF, 2'b00, 2'b11, 16'hFFFF, w0, w1, aa, ao, a1);
        tests++;
        if ({w1, w0} !== 16'h0000) begin fails++; $display("FAIL lane_en_off_both: got %h expected 0000", {w1, w0}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        logic aa, ao, a1;
        a_word(2'b11, 2'b01, 16'h00A5, 2'b11, 2'b01, 16'h003C, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'hA5 || w1 !== 8'hBC) begin
            fails++; $display("FAIL b2b_first: got %h/%h expected a5/bc", w0, w1);
        end
        a_word(2'b11, 2'b01, 16'h003C, 2'b11, 2'b00, 16'h0000, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'h3C) begin fails++; $display("FAIL b2b_second: got %h expected 3c", w0); end
        tests++;
        if (aa !== 1'b1 || a1 !== 1'b0) begin
            fails++; $display("FAIL b2b_active: got l0_all=%b l1_any=%b expected 1/0", aa, a1);
        end
    endtask

    // Reset partway through A5: output zero during reset, no leftover bits.
    task automatic test_mid_reset();
        logic [7:0] w0, w1;
        logic aa, ao, a1;
        logic [2:0] head;
        a_en = 2'b01; a_valid = 2'b01; a_data = 16'h00A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            head[2-i] = a_dout[0];
        end
        tests++;
        if (head !== 3'b101) begin fails++; $display("FAIL midreset_head: got %b expected 101", head); end
        a_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (a_dout !== 2'b00 || a_load !== 1'b1 || a_act !== 2'b00) begin
                fails++;
                $display("FAIL midreset_hold%0d: got dout=%b load=%b act=%b expected 00/1/00",
                         i, a_dout, a_load, a_act);
            end
        end
        a_reset = 1'b0;
        a_word(2'b01, 2'b01, 16'h00C3, 2'b01, 2'b00, 16'h0000, w0, w1, aa, ao, a1);
        tests++;
        if (w0 !== 8'hC3) begin fails++; $display("FAIL midreset_restart: got %h expected c3", w0); end
        tests++;
        if (aa !== 1'b1) begin fails++; $display("FAIL midreset_active: got %b expected 1", aa); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic aa, ao;
        b_reset = 1'b1; tick(); tick();
        tests++;
        if (b_dout !== 1'b0 || b_load !== 1'b1) begin
            fails++; $display("FAIL lsb_reset: got dout=%b load=%b expected 0/1", b_dout, b_load);
        end
        b_reset = 1'b0;
        b_word(1'b1, 1'b1, 8'h01, w, aa, ao);
        tests++;
        if (w !== 8'h01) begin fails++; $display("FAIL lsb_01: got %h expected 01", w); end
        b_word(1'b1, 1'b1, 8'hB4, w, aa, ao);
        tests++;
        if (w !== 8'hB4 || aa !== 1'b1) begin
            fails++; $display("FAIL lsb_b4: got %h act=%b expected b4/1", w, aa);
        end
        b_word(1'b1, 1'b0, 8'h00, w, aa, ao);
        tests++;
        if (w !== 8'hBC || ao !== 1'b0) begin
            fails++; $display("FAIL lsb_idle: got %h act=%b expected bc/0", w, ao);
        end
    endtask

    task automatic test_width10();
        logic [9:0] w;
        logic aa, ao;
        int n;
        c_en = 1'b1; c_valid = 1'b0;
        c_reset = 1'b1; tick(); tick();
        c_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (c_load !== 1'b1 && n < 40);
            tests++;
            if (n != 10) begin fails++; $display("FAIL w10_load_period%0d: got %0d expected 10", k, n); end
        end
        c_word(1'b0, 10'h000, w, aa, ao);
        tests++;
        if (w !== 10'h17C || ao !== 1'b0) begin
            fails++; $display("FAIL w10_idle: got %h act=%b expected 17c/0", w, ao);
        end
        c_word(1'b1, 10'h2A5, w, aa, ao);
        tests++;
        if (w !== 10'h2A5 || aa !== 1'b1) begin
            fails++; $display("FAIL w10_valid: got %h act=%b expected 2a5/1", w, aa);
        end
        c_word(1'b0, 10'h000, w, aa, ao);
        tests++;
        if (w !== 10'h17C) begin fails++; $display("FAIL w10_idle_after: got %h expected 17c", w); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_valid_word();
        test_lane_en();
        test_back_to_back();
        test_mid_reset();
        test_lsb_first();
        test_width10();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
